// File: rtl/datapath_sequencer_if.sv
// Control bundle between the instruction source, the sequencer and the datapath.
// The master side issues instructions; the slave side is the sequencer itself.
interface datapath_sequencer_if #(
  parameter int NREGS  = 16,
  parameter int DATA_W = 16
);
  logic              start;
  logic [15:0]       instr;
  logic              busy;
  logic              done;
  logic              err;
  logic [3:0]        srcA_sel;
  logic [3:0]        srcB_sel;
  logic              imm_sel;
  logic [DATA_W-1:0] imm;
  logic [3:0]        alu_op;
  logic [NREGS-1:0]  regEn;
  logic              flags_en;

  modport master (
    output start, instr,
    input  busy, done, err, srcA_sel, srcB_sel, imm_sel, imm, alu_op, regEn, flags_en
  );

  modport slave (
    input  start, instr,
    output busy, done, err, srcA_sel, srcB_sel, imm_sel, imm, alu_op, regEn, flags_en
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Five-state sequencer that runs one instruction at a time through the register file and ALU.
// Every datapath control is derived from the latched instruction and the current state.
module datapath_sequencer #(
  parameter int NREGS  = 16,
  parameter int DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  datapath_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hB;

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;

  logic [3:0] opField;
  logic [3:0] extField;
  logic [3:0] rdest;
  logic [3:0] rsrc;
  logic       regFormat;
  logic [3:0] aluCode;
  logic       legal;
  logic       writesReg;
  logic       setsFlags;

  function automatic logic isLegalCode(input logic [3:0] code);
    case (code)
      4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD: isLegalCode = 1'b1;
      default:                                  isLegalCode = 1'b0;
    endcase
  endfunction

  assign opField   = instr_q[15:12];
  assign rdest     = instr_q[11:8];
  assign extField  = instr_q[7:4];
  assign rsrc      = instr_q[3:0];
  assign regFormat = (opField == 4'h0);
  // Register format carries the ALU code in ext; immediate format reuses op as the ALU code.
  assign aluCode   = regFormat ? extField : opField;
  assign legal     = isLegalCode(aluCode);
  assign writesReg = legal && (aluCode != OP_CMP);
  assign setsFlags = legal && ((aluCode == OP_ADD) || (aluCode == OP_SUB) || (aluCode == OP_CMP));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          instr_d = bus.instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_WRITE;
      S_WRITE:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are purely decoded from state, so an async reset clears regEn immediately.
  always_comb begin
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.err      = 1'b0;
    bus.srcA_sel = '0;
    bus.srcB_sel = '0;
    bus.imm_sel  = 1'b0;
    bus.imm      = '0;
    bus.alu_op   = '0;
    bus.regEn    = '0;
    bus.flags_en = 1'b0;
    if (state_q != S_IDLE) begin
      bus.busy     = 1'b1;
      bus.srcA_sel = rdest;
      bus.srcB_sel = rsrc;
      bus.imm_sel  = !regFormat;
      bus.imm      = {{(DATA_W-8){instr_q[7]}}, instr_q[7:0]};
      bus.alu_op   = aluCode;
    end
    if (state_q == S_WRITE) begin
      if (writesReg) begin
        bus.regEn = {{(NREGS-1){1'b0}}, 1'b1} << rdest;
      end
      bus.flags_en = setsFlags;
    end
    if (state_q == S_DONE) begin
      bus.done = 1'b1;
      bus.err  = !legal;
    end
  end

endmodule
